// File: rtl/iter_mul_pkg.sv
// rtl/iter_mul_pkg.sv - shared types and constants for the iterative multiplier
// Contents: FSM state type, accumulator guard width, counter width helper.
package iter_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iter_mul_state_t;

    // Extra accumulator bits above 2*WIDTH in multiply-accumulate builds.
    localparam int ACC_GUARD = 4;

    // Bits needed for a step counter running 0 .. width-1 (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/iter_mul_step.sv
// rtl/iter_mul_step.sv - one combinational shift-and-add multiplication step
// Ports:
//   mcand/mplier/prod           current multiplicand, multiplier, product
//   mcand_next/mplier_next/prod_next  values after one conditional add and shift
module iter_mul_step
    import iter_mul_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PROD_W = 2 * WIDTH
) (
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [PROD_W-1:0]  prod,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next,
    output logic [PROD_W-1:0]  prod_next
);

    always_comb begin
        prod_next = prod;
        if (mplier[0]) begin
            prod_next = prod + PROD_W'(mcand);
        end
        mcand_next  = {mcand[2*WIDTH-2:0], 1'b0};
        mplier_next = {1'b0, mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/iter_mul_unit.sv
// rtl/iter_mul_unit.sv - sequential unsigned shift-and-add multiplier, one partial product per cycle
// Optional feature macro: ITER_MUL_ACCUM_EN (multiply-accumulate with acc_clr port).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/a/b    operand handshake (acc_clr sampled with operands when accumulating)
//   out_valid/out_ready/p    result handshake
//   busy                     high while computing or holding a result
module iter_mul_unit
    import iter_mul_pkg::*;
#(
    parameter int WIDTH = 4,
`ifdef ITER_MUL_ACCUM_EN
    localparam int PROD_W = 2 * WIDTH + ACC_GUARD
`else
    localparam int PROD_W = 2 * WIDTH
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
`ifdef ITER_MUL_ACCUM_EN
    input  logic              acc_clr,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [PROD_W-1:0]  prod;
    // Low during reset and for the first edge after release, so in_ready
    // stays low while rst is high even though state already reads IDLE.
    logic               live;

    logic [2*WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [PROD_W-1:0]  prod_next;
    logic [PROD_W-1:0]  prod_start;

    iter_mul_step #(
        .WIDTH  (WIDTH),
        .PROD_W (PROD_W)
    ) u_step (
        .mcand       (mcand),
        .mplier      (mplier),
        .prod        (prod),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next),
        .prod_next   (prod_next)
    );

`ifdef ITER_MUL_ACCUM_EN
    assign prod_start = acc_clr ? '0 : prod;
`else
    assign prod_start = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        prod   <= prod_start;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    prod   <= prod_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = live && (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign p         = prod;

endmodule

// File: tb/tb_iter_mul_unit.sv
// tb/tb_iter_mul_unit.sv - self-checking bench for iter_mul_unit with directed and random traffic
module tb_iter_mul_unit;
    import iter_mul_pkg::*;

    localparam int W = 4;
`ifdef ITER_MUL_ACCUM_EN
    localparam int PW = 2 * W + ACC_GUARD;
`else
    localparam int PW = 2 * W;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] p;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] acc_m = '0;

    iter_mul_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ITER_MUL_ACCUM_EN
        .acc_clr   (acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic logic [PW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic clr);
        logic [63:0] prodv;
        prodv = 64'(av) * 64'(bv);
`ifdef ITER_MUL_ACCUM_EN
        if (clr) acc_m = '0;
        acc_m = PW'(64'(acc_m) + prodv);
        return acc_m;
`else
        return PW'(prodv);
`endif
    endfunction

    // Full transaction: present operands, wait result, optional back-pressure, drain.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic clr,
                         input int gap, input int hold, input bit poke, input string tag);
        logic [PW-1:0] exp;
        int t;
        int lat;
        repeat (gap) @(negedge clk);
        exp = model(av, bv, clr);
        a = av; b = bv; acc_clr = clr; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s_accept", tag), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); acc_clr = 1'(($urandom));
        // lat counts edges after the accept edge up to the first edge with out_valid high
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s_lat", tag), 64'(lat), 64'(W + 1));
        chk($sformatf("%s_p", tag), 64'(p), 64'(exp));
        in_valid = poke;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s_hold_valid", tag), 64'(out_valid), 64'd1);
            chk($sformatf("%s_hold_p", tag), 64'(p), 64'(exp));
            chk($sformatf("%s_hold_ready", tag), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s_ready_after", tag), 64'(in_ready), 64'd1);
        chk($sformatf("%s_valid_after", tag), 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_p", 64'(p), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        do_op(4'd15, 4'd15, 1'b1, 0, 0, 1'b0, "mul_15x15");
        do_op(4'd0, 4'd9, 1'b1, 0, 0, 1'b0, "mul_0x9");
        do_op(4'd7, 4'd0, 1'b1, 0, 0, 1'b0, "mul_7x0");
        do_op(4'd6, 4'd11, 1'b1, 0, 10, 1'b1, "mul_6x11_bp");

        // Reset in the middle of RUN
        a = 4'd13; b = 4'd13; acc_clr = 1'b0; in_valid = 1'b1;
        while (!in_ready) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_p", 64'(p), 64'd0);
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_ready", 64'(in_ready), 64'd0);
        acc_m = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(4'd3, 4'd5, 1'b0, 0, 0, 1'b0, "mul_3x5_after_rst");

`ifdef ITER_MUL_ACCUM_EN
        do_op(4'd3, 4'd5, 1'b1, 0, 0, 1'b0, "mac_3x5_clr");
        chk("mac_seq1", 64'(p), 64'd15);
        do_op(4'd2, 4'd2, 1'b0, 0, 0, 1'b0, "mac_2x2_keep");
        chk("mac_seq2", 64'(p), 64'd19);
        do_op(4'd1, 4'd1, 1'b1, 0, 0, 1'b0, "mac_1x1_clr");
        chk("mac_seq3", 64'(p), 64'd1);
`endif

        for (int n = 0; n < 60; n++) begin
            do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
